// File: rtl/i2c_master_read_bit.sv
// Bit-level I2C master receiver: drives one SCL pulse with SDA released,
// samples SDA mid-high and reports the bit plus bus-error / stretch-timeout.
module i2c_master_read_bit #(
  parameter int QUARTER     = 5,
  parameter int STRETCH_MAX = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic scl_in,
  input  logic sda_in,
  output logic finish,
  output logic data,
  output logic error,
  output logic scl,
  output logic sda
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH_WAIT,
    HIGH,
    DONE
  } state_e;

  localparam int          SW           = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
  localparam logic [8:0]  PHASE_LAST   = 9'(2 * QUARTER - 1);
  localparam logic [8:0]  SAMPLE_AT    = 9'(QUARTER);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_MAX - 1);

  state_e          state_q, state_d;
  logic [8:0]      phase_q, phase_d;
  logic [SW-1:0]   stretch_q, stretch_d;
  logic            scl_q, scl_d;
  logic            data_q, data_d;
  logic            error_q, error_d;
  logic            ref_q, ref_d;
  logic            mismatch;

  // State and datapath registers; reset releases SCL and drops any partial bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      stretch_q <= '0;
      scl_q     <= 1'b1;
      data_q    <= 1'b0;
      error_q   <= 1'b0;
      ref_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stretch_q <= stretch_d;
      scl_q     <= scl_d;
      data_q    <= data_d;
      error_q   <= error_d;
      ref_q     <= ref_d;
    end
  end

  // Next-state logic: low phase, wait for released SCL, high phase, handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go) state_d = LOW;
      LOW:       if (phase_q == PHASE_LAST) state_d = HIGH_WAIT;
      HIGH_WAIT: begin
        if (scl_in)                         state_d = HIGH;
        else if (stretch_q == STRETCH_LAST) state_d = DONE;
      end
      HIGH:      if (phase_q == PHASE_LAST) state_d = DONE;
      DONE:      if (!go) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counters, SCL drive, SDA reference capture, sampling and error detection
  always_comb begin
    phase_d   = phase_q;
    stretch_d = stretch_q;
    scl_d     = scl_q;
    data_d    = data_q;
    error_d   = error_q;
    ref_d     = ref_q;
    mismatch  = (state_q == HIGH) && (phase_q != 9'd0) && (sda_in != ref_q);
    case (state_q)
      IDLE: begin
        if (go) begin
          phase_d   = '0;
          stretch_d = '0;
          data_d    = 1'b0;
          error_d   = 1'b0;
          scl_d     = 1'b0;
        end
      end
      LOW: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          scl_d   = 1'b1;
        end else begin
          phase_d = phase_q + 9'd1;
        end
      end
      HIGH_WAIT: begin
        if (!scl_in) begin
          if (stretch_q == STRETCH_LAST) error_d = 1'b1;
          else                           stretch_d = stretch_q + 1'b1;
        end
      end
      HIGH: begin
        if (phase_q == 9'd0) ref_d = sda_in;
        if (mismatch) error_d = 1'b1;
        if (phase_q == SAMPLE_AT) data_d = (error_q || mismatch) ? 1'b0 : sda_in;
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          scl_d   = 1'b0;
        end else begin
          phase_d = phase_q + 9'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: finish is decoded from DONE, SDA is never driven low by a reader
  always_comb begin
    finish = (state_q == DONE);
    data   = data_q;
    error  = error_q;
    scl    = scl_q;
    sda    = 1'b1;
  end

endmodule
